// File: rtl/action_executor.sv
// action_executor: fetches a matched action entry and applies NOP/SET/DROP to packet memory.
// Define EXEC_ADD_EN to make opcode 3 (ADD) legal; it adds the READ_FLD state and the field adder.
`ifndef ADDR_BUS
`define ADDR_BUS 31:0
`endif
`ifndef DATA_BUS
`define DATA_BUS 31:0
`endif
`ifndef NUM_HEADERS
`define NUM_HEADERS 8
`endif

module action_executor #(
  parameter int unsigned MAX_VAL_LEN = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_i,
  input  logic [`ADDR_BUS]             val_addr_i,
  input  logic [`NUM_HEADERS*32-1:0]   parsed_hdrs_i,
  output logic                         mem_ce_o,
  output logic                         mem_we_o,
  output logic [`ADDR_BUS]             mem_addr_o,
  output logic [3:0]                   mem_width_o,
  output logic [`DATA_BUS]             mem_data_o,
  input  logic [`DATA_BUS]             mem_data_i,
  output logic                         ready_o,
  output logic                         drop_o,
  output logic                         err_o
);

  localparam logic [2:0] StFree     = 3'd0;
  localparam logic [2:0] StLoadDesc = 3'd1;
  localparam logic [2:0] StLoadVal  = 3'd2;
  localparam logic [2:0] StWrite    = 3'd4;
  localparam logic [2:0] StDone     = 3'd5;

  localparam int unsigned ValW   = 8 * MAX_VAL_LEN;
  localparam logic [4:0]  MaxLen = 5'(MAX_VAL_LEN);
  localparam logic [4:0]  NumHdr = 5'(`NUM_HEADERS);

  localparam logic [7:0] OpNop  = 8'd0;
  localparam logic [7:0] OpSet  = 8'd1;
  localparam logic [7:0] OpDrop = 8'd2;

  logic [2:0]      state_q;
  logic [7:0]      opcode_q;
  logic [3:0]      hdr_q;
  logic [5:0]      off_q;
  logic [3:0]      len_q;
  logic [3:0]      cnt_q;
  logic [31:0]     fbase_q;
  logic [ValW-1:0] val_q;
  logic [ValW-1:0] res;
  logic [ValW-1:0] res_sh;
  logic [3:0]      wr_sh;
  logic [31:0]     hdr_base;
  logic [7:0]      rd_byte;
  logic            len_bad;
  logic            hdr_bad;
  logic            op_rmw;
  logic            last_byte;
  logic            unused_data;

  assign rd_byte     = mem_data_i[7:0];
  assign unused_data = ^mem_data_i[31:8];
  assign mem_width_o = 4'd1;
  assign len_bad     = (rd_byte[3:0] == 4'd0) || ({1'b0, rd_byte[3:0]} > MaxLen);
  assign hdr_bad     = ({1'b0, hdr_q} >= NumHdr);
  assign last_byte   = (cnt_q == len_q - 4'd1);

`ifdef EXEC_ADD_EN
  localparam logic [2:0] StReadFld = 3'd3;
  localparam logic [7:0] OpAdd     = 8'd3;
  logic [ValW-1:0] fld_q;
  // Whole-field add; carry ripples from the last (least significant) byte upward.
  assign res    = (opcode_q == OpAdd) ? val_q + fld_q : val_q;
  assign op_rmw = (opcode_q == OpSet) || (opcode_q == OpAdd);
`else
  assign res    = val_q;
  assign op_rmw = (opcode_q == OpSet);
`endif

  always_comb begin
    hdr_base = '0;
    for (int h = 0; h < `NUM_HEADERS; h++) begin
      if ({1'b0, hdr_q} == 5'(h)) hdr_base = parsed_hdrs_i[h*32 +: 32];
    end
  end

  // Field bytes are big-endian: write index 0 is the most significant byte of res.
  assign wr_sh  = len_q - cnt_q - 4'd1;
  assign res_sh = res >> {wr_sh, 3'b000};

  always_comb begin
    mem_data_o = '0;
    if (state_q == StWrite) mem_data_o[7:0] = res_sh[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StFree;
      opcode_q   <= '0;
      hdr_q      <= '0;
      off_q      <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      fbase_q    <= '0;
      val_q      <= '0;
`ifdef EXEC_ADD_EN
      fld_q      <= '0;
`endif
      mem_ce_o   <= 1'b0;
      mem_we_o   <= 1'b0;
      mem_addr_o <= '0;
      ready_o    <= 1'b0;
      drop_o     <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      case (state_q)
        StFree: begin
          if (start_i) begin
            ready_o <= 1'b0;
            drop_o  <= 1'b0;
            err_o   <= 1'b0;
            cnt_q   <= '0;
            val_q   <= '0;
`ifdef EXEC_ADD_EN
            fld_q   <= '0;
`endif
            if (val_addr_i == '0) begin
              state_q <= StDone;
            end else begin
              mem_ce_o   <= 1'b1;
              mem_addr_o <= val_addr_i;
              state_q    <= StLoadDesc;
            end
          end
        end
        StLoadDesc: begin
          mem_addr_o <= mem_addr_o + 1'b1;
          cnt_q      <= cnt_q + 4'd1;
          case (cnt_q)
            4'd0: opcode_q <= rd_byte;
            4'd1: hdr_q    <= rd_byte[3:0];
            4'd2: off_q    <= rd_byte[5:0];
            default: begin
              // Len byte is decoded straight off the read port to save a cycle.
              len_q   <= rd_byte[3:0];
              cnt_q   <= '0;
              fbase_q <= hdr_base + {26'b0, off_q};
              if (op_rmw && !len_bad && !hdr_bad) begin
                state_q <= StLoadVal;
              end else begin
                mem_ce_o <= 1'b0;
                state_q  <= StDone;
                if (opcode_q == OpDrop) drop_o <= 1'b1;
                else if (opcode_q != OpNop) err_o <= 1'b1;
              end
            end
          endcase
        end
        StLoadVal: begin
          val_q      <= {val_q[ValW-9:0], rd_byte};
          mem_addr_o <= mem_addr_o + 1'b1;
          cnt_q      <= cnt_q + 4'd1;
          if (last_byte) begin
            cnt_q      <= '0;
            mem_addr_o <= fbase_q;
`ifdef EXEC_ADD_EN
            if (opcode_q == OpAdd) begin
              state_q <= StReadFld;
            end else begin
              mem_we_o <= 1'b1;
              state_q  <= StWrite;
            end
`else
            mem_we_o <= 1'b1;
            state_q  <= StWrite;
`endif
          end
        end
`ifdef EXEC_ADD_EN
        StReadFld: begin
          fld_q      <= {fld_q[ValW-9:0], rd_byte};
          mem_addr_o <= mem_addr_o + 1'b1;
          cnt_q      <= cnt_q + 4'd1;
          if (last_byte) begin
            cnt_q      <= '0;
            mem_addr_o <= fbase_q;
            mem_we_o   <= 1'b1;
            state_q    <= StWrite;
          end
        end
`endif
        StWrite: begin
          mem_addr_o <= mem_addr_o + 1'b1;
          cnt_q      <= cnt_q + 4'd1;
          if (last_byte) begin
            mem_ce_o <= 1'b0;
            mem_we_o <= 1'b0;
            state_q  <= StDone;
          end
        end
        StDone: begin
          if (!start_i) begin
            ready_o <= 1'b0;
            state_q <= StFree;
          end else begin
            ready_o <= 1'b1;
          end
        end
        default: state_q <= StFree;
      endcase
    end
  end

endmodule

// File: tb/tb_action_executor.sv
// tb_action_executor: randomized + directed checks of action_executor against a byte-level entry model.
`ifndef ADDR_BUS
`define ADDR_BUS 31:0
`endif
`ifndef DATA_BUS
`define DATA_BUS 31:0
`endif
`ifndef NUM_HEADERS
`define NUM_HEADERS 8
`endif

module tb_action_executor;
`ifdef EXEC_ADD_EN
  localparam bit AddEn = 1'b1;
`else
  localparam bit AddEn = 1'b0;
`endif

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       start_i;
  logic [31:0]                val_addr_i;
  logic [`NUM_HEADERS*32-1:0] parsed_hdrs_i;
  logic                       mem_ce_o;
  logic                       mem_we_o;
  logic [31:0]                mem_addr_o;
  logic [3:0]                 mem_width_o;
  logic [31:0]                mem_data_o;
  logic [31:0]                mem_data_i;
  logic                       ready_o;
  logic                       drop_o;
  logic                       err_o;

  always #5 clk = ~clk;

  action_executor #(.MAX_VAL_LEN(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .val_addr_i    (val_addr_i),
    .parsed_hdrs_i (parsed_hdrs_i),
    .mem_ce_o      (mem_ce_o),
    .mem_we_o      (mem_we_o),
    .mem_addr_o    (mem_addr_o),
    .mem_width_o   (mem_width_o),
    .mem_data_o    (mem_data_o),
    .mem_data_i    (mem_data_i),
    .ready_o       (ready_o),
    .drop_o        (drop_o),
    .err_o         (err_o)
  );

  logic [7:0]  mem     [1024];
  logic [7:0]  exp_mem [1024];
  logic [31:0] hdrs    [8];
  logic [31:0] wq_addr [$];
  logic [7:0]  wq_data [$];
  int          n_checks = 0;
  int          n_pass   = 0;

  assign mem_data_i = {24'h0, mem[mem_addr_o[9:0]]};

  // Writes are logged and folded into mem after each action.
  always @(posedge clk) begin
    if (mem_ce_o && mem_we_o) begin
      wq_addr.push_back(mem_addr_o);
      wq_data.push_back(mem_data_o[7:0]);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [7:0] byte_at(input logic [31:0] a);
    return mem[a[9:0]];
  endfunction

  task automatic load_hdrs();
    for (int h = 0; h < 8; h++) parsed_hdrs_i[h*32 +: 32] = hdrs[h];
  endtask

  task automatic put_entry(input logic [31:0] a, input logic [7:0] op, input logic [7:0] hid,
                           input logic [7:0] off, input logic [7:0] len);
    mem[a[9:0]]      = op;
    mem[a[9:0] + 1]  = hid;
    mem[a[9:0] + 2]  = off;
    mem[a[9:0] + 3]  = len;
    for (int i = 0; i < 12; i++) mem[a[9:0] + 10'(4 + i)] = 8'($urandom);
  endtask

  // Expected result of one action on the current memory image.
  task automatic model(input logic [31:0] a, output int lat, output bit drop, output bit err,
                       output int nwr);
    int op, hid, off, len;
    logic [63:0] v, f, r;
    logic [31:0] fb;
    foreach (exp_mem[i]) exp_mem[i] = mem[i];
    lat = 5; drop = 0; err = 0; nwr = 0;
    if (a == 0) begin
      lat = 1;
      return;
    end
    op  = int'(byte_at(a));
    hid = int'(byte_at(a + 1)) % 16;
    off = int'(byte_at(a + 2)) % 64;
    len = int'(byte_at(a + 3)) % 16;
    if (op == 2) begin
      drop = 1;
    end else if (op == 1 || (op == 3 && AddEn)) begin
      if (len == 0 || len > 8 || hid >= 8) begin
        err = 1;
        return;
      end
      fb = hdrs[hid] + 32'(off);
      v = 0;
      f = 0;
      for (int i = 0; i < len; i++) v = (v << 8) | 64'(byte_at(a + 32'(4 + i)));
      for (int i = 0; i < len; i++) f = (f << 8) | 64'(byte_at(fb + 32'(i)));
      r = (op == 3) ? v + f : v;
      for (int i = 0; i < len; i++) begin
        logic [31:0] wa;
        wa = fb + 32'(i);
        exp_mem[wa[9:0]] = 8'(r >> (8 * (len - 1 - i)));
      end
      nwr = len;
      lat = 5 + ((op == 3) ? 3 : 2) * len;
    end else if (op != 0) begin
      err = 1;
    end
  endtask

  task automatic run(input logic [31:0] a, input string tag, input int hold);
    int lat, nwr, cyc, nbad;
    bit drop, err;
    model(a, lat, drop, err, nwr);
    wq_addr.delete();
    wq_data.delete();
    @(negedge clk);
    val_addr_i = a;
    start_i    = 1'b1;
    @(posedge clk);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!ready_o && cyc < 200);
    check({tag, ".lat"}, 64'(cyc), 64'(lat));
    check({tag, ".drop"}, 64'(drop_o), 64'(drop));
    check({tag, ".err"}, 64'(err_o), 64'(err));
    check({tag, ".nwr"}, 64'(wq_addr.size()), 64'(nwr));
    foreach (wq_addr[i]) mem[wq_addr[i][9:0]] = wq_data[i];
    nbad = 0;
    foreach (mem[i]) if (mem[i] !== exp_mem[i]) nbad++;
    check({tag, ".mem"}, 64'(nbad), 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, ".held"}, 64'(ready_o), 64'd1);
    end
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check({tag, ".idle"}, 64'(ready_o), 64'd0);
    check({tag, ".flags"}, 64'({drop_o, err_o}), 64'({drop, err}));
  endtask

  initial begin
    int cyc;
    rst        = 1'b1;
    start_i    = 1'b0;
    val_addr_i = '0;
    foreach (mem[i]) mem[i] = 8'($urandom);
    for (int h = 0; h < 8; h++) hdrs[h] = 32'($urandom_range(16, 240));
    load_hdrs();
    #12;
    check("rst.ctl", 64'({mem_ce_o, mem_we_o, ready_o, drop_o, err_o}), 64'd0);
    check("rst.addr", 64'(mem_addr_o), 64'd0);
    check("rst.data", 64'(mem_data_o), 64'd0);
    check("rst.width", 64'(mem_width_o), 64'd1);
    @(negedge clk);
    rst = 1'b0;

    run(32'h0, "miss", 1);

    hdrs[2] = 32'h40;
    load_hdrs();
    put_entry(32'h200, 8'h01, 8'h02, 8'h04, 8'h02);
    mem[10'h204] = 8'hAB;
    mem[10'h205] = 8'hCD;
    run(32'h200, "set", 0);
    check("set.b0", 64'(mem[10'h044]), 64'hAB);
    check("set.b1", 64'(mem[10'h045]), 64'hCD);

    put_entry(32'h210, 8'h02, 8'h01, 8'h00, 8'h03);
    run(32'h210, "drop", 0);
    put_entry(32'h220, 8'h01, 8'h02, 8'h04, 8'h09);
    run(32'h220, "len9", 0);
    put_entry(32'h230, 8'h01, 8'h0F, 8'h04, 8'h02);
    run(32'h230, "hdr15", 0);
    put_entry(32'h240, 8'h07, 8'h02, 8'h04, 8'h02);
    run(32'h240, "op7", 0);

    mem[10'h044] = 8'h00;
    mem[10'h045] = 8'hFF;
    put_entry(32'h250, 8'h03, 8'h02, 8'h04, 8'h02);
    mem[10'h254] = 8'h00;
    mem[10'h255] = 8'h01;
    run(32'h250, "add", 0);
    check("add.b0", 64'(mem[10'h044]), AddEn ? 64'h01 : 64'h00);
    check("add.b1", 64'(mem[10'h045]), AddEn ? 64'h00 : 64'hFF);

    // Abort a 4-byte SET while its second byte is on the bus.
    put_entry(32'h260, 8'h01, 8'h03, 8'h10, 8'h04);
    wq_addr.delete();
    wq_data.delete();
    @(negedge clk);
    val_addr_i = 32'h260;
    start_i    = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!mem_we_o && cyc < 100);
    check("abort.wait", 64'(mem_we_o), 64'd1);
    @(posedge clk);
    #1;
    rst     = 1'b1;
    start_i = 1'b0;
    #1;
    check("abort.ctl", 64'({mem_ce_o, mem_we_o, ready_o, drop_o, err_o}), 64'd0);
    check("abort.addr", 64'(mem_addr_o), 64'd0);
    check("abort.data", 64'(mem_data_o), 64'd0);
    check("abort.nwr", 64'(wq_addr.size()), 64'd1);
    foreach (wq_addr[i]) mem[wq_addr[i][9:0]] = wq_data[i];
    @(negedge clk);
    rst = 1'b0;
    run(32'h260, "rerun", 3);

    for (int k = 0; k < 40; k++) begin
      logic [31:0] a;
      logic [7:0] op, hid, len;
      int sel;
      for (int h = 0; h < 8; h++) hdrs[h] = 32'($urandom_range(16, 240));
      load_hdrs();
      a   = 32'h200 + 32'(16 * (k % 32));
      sel = int'($urandom_range(0, 9));
      if (sel == 0) op = 8'h00;
      else if (sel <= 4) op = 8'h01;
      else if (sel == 5) op = 8'h02;
      else if (sel <= 7) op = 8'h03;
      else if (sel == 8) op = 8'h07;
      else op = 8'($urandom_range(4, 255));
      hid = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(8, 15)) : 8'($urandom_range(0, 7));
      len = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(1, 8));
      put_entry(a, op, hid, 8'($urandom_range(0, 63)), len);
      run(a, "rand", int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
